// File: rtl/cla_8bit_with_2_four_bit_if.sv
// Operand/result bundle for the 8-bit CLA adder/subtractor.
// The master drives the operands and the slave (the adder) returns the registered result.
interface cla_8bit_with_2_four_bit_if;
    logic [7:0] A;
    logic [7:0] B;
    logic       op;
    logic [7:0] S;
    logic       cout;
    logic       overflow;

    modport master (
        output A, B, op,
        input  S, cout, overflow
    );

    modport slave (
        input  A, B, op,
        output S, cout, overflow
    );
endinterface

// File: rtl/cla_8bit_with_2_four_bit.sv
// Registered 8-bit add/sub built from two 4-bit CLA slices and a second-level carry unit.
// Optional macro CLA_SATURATE_EN clamps S to 7F/80 on signed overflow.
module cla_8bit_with_2_four_bit (
    input  logic clk,
    input  logic rst,
    cla_8bit_with_2_four_bit_if.slave bus
);
    localparam int unsigned W  = 8;
    localparam int unsigned SW = 4;

    // Flat 4-bit lookahead: returns {gp, gg, c3, c2, c1}
    function automatic logic [4:0] cla4(input logic [SW-1:0] g,
                                        input logic [SW-1:0] p,
                                        input logic          ci);
        logic c1, c2, c3, gg, gp;
        c1 = g[0] | (p[0] & ci);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        gp = &p;
        return {gp, gg, c3, c2, c1};
    endfunction

    logic [W-1:0] bb, g, p, c, sum;
    logic [4:0]   lo, hi;
    logic         c4, c8, ov;
    logic [W-1:0] s_d, s_q;
    logic         cout_d, cout_q, ov_d, ov_q;

    always_comb begin
        bb  = bus.B ^ {W{bus.op}};
        g   = bus.A & bb;
        p   = bus.A ^ bb;
        lo  = cla4(g[SW-1:0], p[SW-1:0], bus.op);
        // High slice carry-in comes straight from the group unit, not from the low slice's c3
        c4  = lo[3] | (lo[4] & bus.op);
        hi  = cla4(g[W-1:SW], p[W-1:SW], c4);
        c8  = hi[3] | (hi[4] & lo[3]) | (hi[4] & lo[4] & bus.op);
        c   = {hi[2:0], c4, lo[2:0], bus.op};
        sum = p ^ c;
        ov  = c[W-1] ^ c8;

        cout_d = c8;
        ov_d   = ov;
`ifdef CLA_SATURATE_EN
        if (ov) begin
            s_d = bus.A[W-1] ? W'(8'h80) : W'(8'h7F);
        end else begin
            s_d = sum;
        end
`else
        s_d = sum;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q    <= '0;
            cout_q <= 1'b0;
            ov_q   <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
            ov_q   <= ov_d;
        end
    end

    assign bus.S        = s_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ov_q;
endmodule

// File: tb/tb_cla_8bit_with_2_four_bit.sv
// Scoreboard bench for cla_8bit_with_2_four_bit: expectations queued at drive time, popped one cycle later.
module tb_cla_8bit_with_2_four_bit;
    logic clk;
    logic rst;

    cla_8bit_with_2_four_bit_if bif ();

    cla_8bit_with_2_four_bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       v;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_vec;
    int   n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sat_s(input logic [7:0] a, input logic [7:0] s, input logic v);
`ifdef CLA_SATURATE_EN
        if (v) return a[7] ? 8'h80 : 8'h7F;
`endif
        return s;
    endfunction

    task automatic compare_pending();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq({e.tag, ".S"},    bif.S,               e.s);
            check_eq({e.tag, ".cout"}, {7'd0, bif.cout},     {7'd0, e.c});
            check_eq({e.tag, ".ovf"},  {7'd0, bif.overflow}, {7'd0, e.v});
        end
    endtask

    // Compare the previous cycle's result, then drive this cycle's operands and queue their result
    task automatic step(input logic r, input logic [7:0] a, input logic [7:0] b, input logic o,
                        input logic [7:0] es, input logic ec, input logic ev, input string tag);
        exp_t e;
        @(negedge clk);
        compare_pending();
        rst    = r;
        bif.A  = a;
        bif.B  = b;
        bif.op = o;
        e.s   = r ? 8'h00 : sat_s(a, es, ev);
        e.c   = r ? 1'b0 : ec;
        e.v   = r ? 1'b0 : ev;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic o,
                         output logic [7:0] s, output logic c, output logic v);
        logic [7:0] bb;
        logic [8:0] full;
        bb   = o ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + 9'(o);
        s    = full[7:0];
        c    = full[8];
        v    = (a[7] == bb[7]) && (full[7] != a[7]);
    endtask

    task automatic table_run(input string pfx);
        step(0, 8'h01, 8'h01, 0, 8'h02, 0, 0, {pfx, "add01_01"});
        step(0, 8'h02, 8'hFE, 0, 8'h00, 1, 0, {pfx, "add02_FE"});
        step(0, 8'hFF, 8'h01, 0, 8'h00, 1, 0, {pfx, "addFF_01"});
        step(0, 8'hFF, 8'hFF, 0, 8'hFE, 1, 0, {pfx, "addFF_FF"});
        step(0, 8'h19, 8'hB1, 1, 8'h68, 0, 0, {pfx, "sub19_B1"});
        step(0, 8'h3D, 8'h35, 1, 8'h08, 1, 0, {pfx, "sub3D_35"});
        step(0, 8'h87, 8'h07, 1, 8'h80, 1, 0, {pfx, "sub87_07"});
        step(0, 8'hA7, 8'h97, 1, 8'h10, 1, 0, {pfx, "subA7_97"});
        step(0, 8'h81, 8'h81, 0, 8'h02, 1, 1, {pfx, "ovf81_81"});
        step(0, 8'h7F, 8'h1F, 0, 8'h9E, 0, 1, {pfx, "ovf7F_1F"});
        step(0, 8'h80, 8'h01, 1, 8'h7F, 1, 1, {pfx, "ovf80_01"});
    endtask

    initial begin
        logic [7:0] a, b, es;
        logic       o, r, ec, ev;
        n_vec  = 0;
        n_err  = 0;
        rst    = 1'b1;
        bif.A  = 8'hFF;
        bif.B  = 8'hFF;
        bif.op = 1'b0;

        step(1, 8'hFF, 8'hFF, 0, 8'h00, 0, 0, "rst0");
        step(1, 8'hFF, 8'hFF, 0, 8'h00, 0, 0, "rst1");
        table_run("a_");

        // Same sequence with a one-cycle reset dropped into the middle
        step(0, 8'h01, 8'h01, 0, 8'h02, 0, 0, "b_add01_01");
        step(0, 8'h02, 8'hFE, 0, 8'h00, 1, 0, "b_add02_FE");
        step(1, 8'h7F, 8'h1F, 0, 8'h00, 0, 0, "b_midrst");
        step(0, 8'h19, 8'hB1, 1, 8'h68, 0, 0, "b_sub19_B1");
        step(0, 8'h81, 8'h81, 0, 8'h02, 1, 1, "b_ovf81_81");

        for (int i = 0; i < 48; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            o = 1'($urandom);
            r = ($urandom_range(0, 15) == 0);
            model(a, b, o, es, ec, ev);
            step(r, a, b, o, es, ec, ev, $sformatf("rnd%0d", i));
        end

        @(negedge clk);
        compare_pending();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
